// File: rtl/game_timer_pkg.sv
// Shared definitions for the game timer: FSM state encoding, BCD digit width
// and a helper that turns a binary second count into two BCD digits.
package game_timer_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [2*BCD_W-1:0] toBcd(input int unsigned value);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(value / 10);
    ones = BCD_W'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/game_timer_tick_sync.sv
// Brings the asynchronous 1 s clock into the clk domain and turns each of its
// rising edges into a single-cycle tick.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sec_in,
  output logic o_tick
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_delay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_delay <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], sec_in};
      r_delay <= r_sync[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronised level; falling edges never produce a tick.
  assign o_tick = r_sync[SYNC_STAGES-1] & ~r_delay;

endmodule

// File: rtl/game_timer.sv
// Round timer: counts GAME_SECS down in BCD on each second tick and flags end of round.
// Optional low-time warning output is built only when TIMER_WARN_EN is defined.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int GAME_SECS   = 30,
  parameter int SYNC_STAGES = 2,
  parameter int WARN_SECS   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sec_in,
  input  logic             start,
  input  logic             pause,
  output logic [BCD_W-1:0] secs_tens,
  output logic [BCD_W-1:0] secs_ones,
  output logic             running,
  output logic             time_up,
  output logic             expired,
  output logic             warn
);

  localparam logic [2*BCD_W-1:0] LOAD_BCD  = toBcd(GAME_SECS);
  localparam logic [BCD_W-1:0]   LOAD_TENS = LOAD_BCD[2*BCD_W-1:BCD_W];
  localparam logic [BCD_W-1:0]   LOAD_ONES = LOAD_BCD[BCD_W-1:0];

  if (GAME_SECS < 1 || GAME_SECS > 99 || SYNC_STAGES < 2 ||
      WARN_SECS < 1 || WARN_SECS > GAME_SECS) begin : g_badParams
    $error("game_timer: illegal parameter value");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [BCD_W-1:0] r_tens;
  logic [BCD_W-1:0] r_ones;
  logic [BCD_W-1:0] w_nextTens;
  logic [BCD_W-1:0] w_nextOnes;
  logic             r_running;
  logic             r_timeUp;
  logic             r_expired;
  logic             w_tick;
  logic             w_load;
  logic             w_dec;
  logic             w_done;
  logic             w_atOne;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tickSync (
    .clk    (clk),
    .rst    (rst),
    .sec_in (sec_in),
    .o_tick (w_tick)
  );

  assign w_atOne = (r_tens == '0) && (r_ones == BCD_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Pause takes priority over a coincident tick; start only acts from IDLE/DONE.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_nextState = ST_RUN;
          w_load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (pause) begin
          w_nextState = ST_PAUSED;
        end else if (w_tick) begin
          w_dec = 1'b1;
          if (w_atOne) begin
            w_nextState = ST_DONE;
            w_done      = 1'b1;
          end
        end
      end
      ST_PAUSED: begin
        if (!pause) begin
          w_nextState = ST_RUN;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_nextTens = r_tens;
    w_nextOnes = r_ones;
    if (w_load) begin
      w_nextTens = LOAD_TENS;
      w_nextOnes = LOAD_ONES;
    end else if (w_dec) begin
      if (r_ones == '0) begin
        w_nextOnes = BCD_W'(9);
        w_nextTens = r_tens - BCD_W'(1);
      end else begin
        w_nextOnes = r_ones - BCD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tens    <= LOAD_TENS;
      r_ones    <= LOAD_ONES;
      r_running <= 1'b0;
      r_timeUp  <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_tens    <= w_nextTens;
      r_ones    <= w_nextOnes;
      r_running <= (w_nextState == ST_RUN);
      r_timeUp  <= w_done;
      r_expired <= (w_nextState == ST_DONE);
    end
  end

`ifdef TIMER_WARN_EN
  localparam logic [2*BCD_W-1:0] WARN_BCD  = toBcd(WARN_SECS);
  localparam logic [BCD_W-1:0]   WARN_TENS = WARN_BCD[2*BCD_W-1:BCD_W];
  localparam logic [BCD_W-1:0]   WARN_ONES = WARN_BCD[BCD_W-1:0];

  logic r_warn;
  logic w_lowTime;
  logic w_active;

  assign w_lowTime = (w_nextTens < WARN_TENS) ||
                     ((w_nextTens == WARN_TENS) && (w_nextOnes <= WARN_ONES));
  assign w_active  = (w_nextState == ST_RUN) || (w_nextState == ST_PAUSED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= w_active && w_lowTime;
    end
  end

  assign warn = r_warn;
`else
  assign warn = 1'b0;
`endif

  assign secs_tens = r_tens;
  assign secs_ones = r_ones;
  assign running   = r_running;
  assign time_up   = r_timeUp;
  assign expired   = r_expired;

endmodule

// File: tb/tb_game_timer.sv
// Self-checking bench for game_timer (GAME_SECS=3, SYNC_STAGES=2, WARN_SECS=2).
// Expected warn follows TIMER_WARN_EN; otherwise warn must stay 0.
module tb_game_timer;

  localparam int GAME_SECS   = 3;
  localparam int SYNC_STAGES = 2;
  localparam int WARN_SECS   = 2;
  localparam int SEC_HALF    = 10;
  localparam int NUM_VEC     = 12;
`ifdef TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       secIn;
  logic       start;
  logic       pause;
  logic [3:0] secsTens;
  logic [3:0] secsOnes;
  logic       running;
  logic       timeUp;
  logic       expired;
  logic       warn;

  always #5 clk = ~clk;

  game_timer #(
    .GAME_SECS  (GAME_SECS),
    .SYNC_STAGES(SYNC_STAGES),
    .WARN_SECS  (WARN_SECS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec_in   (secIn),
    .start    (start),
    .pause    (pause),
    .secs_tens(secsTens),
    .secs_ones(secsOnes),
    .running  (running),
    .time_up  (timeUp),
    .expired  (expired),
    .warn     (warn)
  );

  typedef struct {
    int tens;
    int ones;
    int running;
    int expired;
    int warn;
    int timeUps;
  } expect_t;

  typedef struct {
    logic    start;
    logic    pause;
    logic    secEdge;
    expect_t exp;
  } vector_t;

  expect_t scoreboard[$];
  vector_t vectors[NUM_VEC];
  int      errors = 0;
  int      checks = 0;
  int      tuTotal = 0;
  int      tuMark = 0;

  // Counts time_up pulses so a stretched or missing pulse shows up per step.
  always @(negedge clk) begin
    if (timeUp === 1'b1) tuTotal++;
  end

  function automatic expect_t mkExp(int tens, int ones, int run, int exp, int wrn, int tus);
    expect_t e;
    e.tens    = tens;
    e.ones    = ones;
    e.running = run;
    e.expired = exp;
    e.warn    = WARN_ON ? wrn : 0;
    e.timeUps = tus;
    return e;
  endfunction

  function automatic vector_t mkVec(logic st, logic ps, logic sec, expect_t e);
    vector_t v;
    v.start   = st;
    v.pause   = ps;
    v.secEdge = sec;
    v.exp     = e;
    return v;
  endfunction

  task automatic checkField(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    expect_t e;
    if (scoreboard.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
    end else begin
      e = scoreboard.pop_front();
      checkField({tag, " tens"},    int'(secsTens), e.tens);
      checkField({tag, " ones"},    int'(secsOnes), e.ones);
      checkField({tag, " running"}, int'(running),  e.running);
      checkField({tag, " expired"}, int'(expired),  e.expired);
      checkField({tag, " warn"},    int'(warn),     e.warn);
      checkField({tag, " time_up pulses"}, tuTotal - tuMark, e.timeUps);
      tuMark = tuTotal;
    end
  endtask

  task automatic expectNow(input string tag, input expect_t e);
    scoreboard.push_back(e);
    checkOutput(tag);
  endtask

  // One table step: optional start pulse, pause level, then one full sec_in period.
  task automatic applyStimulus(input vector_t v);
    scoreboard.push_back(v.exp);
    pause = v.pause;
    start = v.start;
    @(posedge clk);
    #1 start = 1'b0;
    if (v.secEdge) secIn = 1'b1;
    repeat (SEC_HALF) @(posedge clk);
    #1 secIn = 1'b0;
    repeat (SEC_HALF) @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    secIn = 1'b0;
    start = 1'b0;
    pause = 1'b0;

    vectors[0]  = mkVec(1'b0, 1'b0, 1'b0, mkExp(0, 3, 0, 0, 0, 0));
    vectors[1]  = mkVec(1'b0, 1'b0, 1'b1, mkExp(0, 3, 0, 0, 0, 0));
    vectors[2]  = mkVec(1'b1, 1'b0, 1'b0, mkExp(0, 3, 1, 0, 0, 0));
    vectors[3]  = mkVec(1'b0, 1'b0, 1'b1, mkExp(0, 2, 1, 0, 1, 0));
    vectors[4]  = mkVec(1'b0, 1'b1, 1'b1, mkExp(0, 2, 0, 0, 1, 0));
    vectors[5]  = mkVec(1'b0, 1'b1, 1'b1, mkExp(0, 2, 0, 0, 1, 0));
    vectors[6]  = mkVec(1'b0, 1'b0, 1'b0, mkExp(0, 2, 1, 0, 1, 0));
    vectors[7]  = mkVec(1'b0, 1'b0, 1'b1, mkExp(0, 1, 1, 0, 1, 0));
    vectors[8]  = mkVec(1'b1, 1'b0, 1'b1, mkExp(0, 0, 0, 1, 0, 1));
    vectors[9]  = mkVec(1'b0, 1'b0, 1'b1, mkExp(0, 0, 0, 1, 0, 0));
    vectors[10] = mkVec(1'b1, 1'b0, 1'b0, mkExp(0, 3, 1, 0, 0, 0));
    vectors[11] = mkVec(1'b0, 1'b0, 1'b1, mkExp(0, 2, 1, 0, 1, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vectors[i]);
      checkOutput($sformatf("vec%0d", i));
    end

    // Latency: count must not move on the 2nd edge after sampling, only on the 3rd.
    secIn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 expectNow("latency before", mkExp(0, 2, 1, 0, 1, 0));
    @(posedge clk);
    @(negedge clk);
    #1 expectNow("latency after", mkExp(0, 1, 1, 0, 1, 0));
    repeat (7) @(posedge clk);
    #1 secIn = 1'b0;
    repeat (SEC_HALF) @(posedge clk);

    // Asynchronous reset mid-cycle at count 01.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 expectNow("async reset", mkExp(0, 3, 0, 0, 0, 0));
    @(posedge clk);
    #1 rst = 1'b0;

    // start coincident with a tick in IDLE: load only, tick not deferred.
    secIn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 expectNow("start+tick", mkExp(0, 3, 1, 0, 0, 0));
    repeat (7) @(posedge clk);
    #1 secIn = 1'b0;
    repeat (SEC_HALF) @(posedge clk);
    #1 expectNow("start+tick later", mkExp(0, 3, 1, 0, 0, 0));

    // pause coincident with a tick in RUN: pause wins, tick lost.
    secIn = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 pause = 1'b1;
    @(posedge clk);
    #1 pause = 1'b0;
    @(negedge clk);
    #1 expectNow("pause+tick", mkExp(0, 3, 0, 0, 0, 0));
    repeat (7) @(posedge clk);
    #1 secIn = 1'b0;
    repeat (SEC_HALF) @(posedge clk);
    #1 expectNow("pause+tick later", mkExp(0, 3, 1, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
